// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmitter slice.
//   DEPTH_DEF  - default transmit FIFO depth in bytes (power of two, >= 2)
//   CLKDIV_DEF - default dclk cycles per SCLK half-period (>= 1)
//   state_t    - serializer FSM state encoding
package spi_pkg;

    localparam int DEPTH_DEF  = 8;
    localparam int CLKDIV_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/tx_fifo.sv
// Byte-wide transmit FIFO with registered count and full flag.
//   dclk  - clock, rising edge
//   rst   - asynchronous active-high reset
//   clr   - synchronous flush; a put or pop in the same cycle is discarded
//   put   - push din (ignored when full unless a pop happens in the same cycle)
//   pop   - remove head; dout shows the head combinationally
//   din   - write data
//   dout  - head of FIFO
//   full  - registered, count == DEPTH
//   empty - count == 0
module tx_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
)
(
    input  logic       dclk,
    input  logic       rst,
    input  logic       clr,
    input  logic       put,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          do_put;
    logic          do_pop;

    assign do_pop = pop && !clr && (count != '0);
    // A pop in the same cycle frees the slot, so a put at full still lands.
    assign do_put = put && !clr && (!full || do_pop);

    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (do_put && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (do_pop && !do_put) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            full   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                // Pointers are exactly log2(DEPTH) bits, so they wrap naturally.
                if (do_put) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge dclk) begin
        if (do_put) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/spi_transmitter.sv
// SPI mode-0 master transmitter with transmit FIFO and receive capture.
//   dclk     - sole clock, rising edge
//   rst      - asynchronous active-high reset
//   clr      - synchronous flush of FIFO and abort of the byte in flight
//   put/din  - push a byte into the transmit FIFO
//   full     - FIFO holds DEPTH bytes
//   busy     - FIFO non-empty or a byte in flight
//   sclk     - SPI clock, idle low
//   mosi     - serial data out, MSB first, idle high
//   miso     - serial data in, sampled on sclk rising edge
//   rx_byte  - byte captured during the last completed transfer
//   rx_valid - one-cycle pulse when rx_byte updates
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for FIFO data; pops head and loads shift register
// SHIFT | toggling sclk every CLKDIV cycles, 8 sclk pulses per byte
// DONE  | publishes rx_byte, pulses rx_valid, returns mosi high
module spi_transmitter
    import spi_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CLKDIV = CLKDIV_DEF
)
(
    input  logic       dclk,
    input  logic       rst,
    input  logic       clr,
    input  logic       put,
    input  logic [7:0] din,
    output logic       full,
    output logic       busy,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);

    localparam int              DW     = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0]   DIV_TC = DW'(CLKDIV - 1);

    state_t        state,    state_nxt;
    logic          sclk_nxt, mosi_nxt, rx_valid_nxt;
    logic [7:0]    tx_sh,    tx_nxt;
    logic [7:0]    rx_sh,    rx_nxt;
    logic [7:0]    rx_byte_nxt;
    logic [3:0]    bit_cnt,  bit_nxt;
    logic [DW-1:0] div,      div_nxt;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_empty;

    tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .dclk  (dclk),
        .rst   (rst),
        .clr   (clr),
        .put   (put),
        .pop   (pop),
        .din   (din),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty)
    );

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sclk     <= 1'b0;
            mosi     <= 1'b1;
            tx_sh    <= 8'h00;
            rx_sh    <= 8'h00;
            bit_cnt  <= 4'd0;
            div      <= '0;
            rx_byte  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            sclk     <= sclk_nxt;
            mosi     <= mosi_nxt;
            tx_sh    <= tx_nxt;
            rx_sh    <= rx_nxt;
            bit_cnt  <= bit_nxt;
            div      <= div_nxt;
            rx_byte  <= rx_byte_nxt;
            rx_valid <= rx_valid_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sclk_nxt     = sclk;
        mosi_nxt     = mosi;
        tx_nxt       = tx_sh;
        rx_nxt       = rx_sh;
        bit_nxt      = bit_cnt;
        div_nxt      = div;
        rx_byte_nxt  = rx_byte;
        rx_valid_nxt = 1'b0;
        pop          = 1'b0;

        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    tx_nxt    = fifo_dout;
                    mosi_nxt  = fifo_dout[7];
                    sclk_nxt  = 1'b0;
                    bit_nxt   = 4'd0;
                    div_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (div == DIV_TC) begin
                    div_nxt  = '0;
                    sclk_nxt = ~sclk;
                    if (!sclk) begin
                        // rising sclk: sample miso
                        rx_nxt  = {rx_sh[6:0], miso};
                        bit_nxt = bit_cnt + 4'd1;
                    end else if (bit_cnt < 4'd8) begin
                        // falling sclk: next bit; tx_sh[7] is the bit just sent
                        tx_nxt   = {tx_sh[6:0], 1'b0};
                        mosi_nxt = tx_sh[6];
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    div_nxt = div + 1'b1;
                end
            end
            DONE: begin
                rx_byte_nxt  = rx_sh;
                rx_valid_nxt = 1'b1;
                mosi_nxt     = 1'b1;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Flush wins over everything, including a pending DONE publish.
        if (clr) begin
            state_nxt    = IDLE;
            sclk_nxt     = 1'b0;
            mosi_nxt     = 1'b1;
            rx_byte_nxt  = rx_byte;
            rx_valid_nxt = 1'b0;
            pop          = 1'b0;
        end
    end

    assign busy = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_spi_transmitter.sv
// Directed self-checking bench for spi_transmitter (DEPTH=8, CLKDIV=2).
module tb_spi_transmitter;

    logic       dclk = 1'b0;
    logic       rst, clr, put, miso, miso_drv, loop;
    logic [7:0] din;
    logic       full, busy, sclk, mosi, rx_valid;
    logic [7:0] rx_byte;

    int checks = 0;
    int errors = 0;

    assign miso = loop ? mosi : miso_drv;

    spi_transmitter #(.DEPTH(8), .CLKDIV(2)) dut (
        .dclk     (dclk),
        .rst      (rst),
        .clr      (clr),
        .put      (put),
        .din      (din),
        .full     (full),
        .busy     (busy),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid)
    );

    always #5 dclk = ~dclk;

    // Monitor: received bytes, their cycle stamps, sclk rises and mosi at each rise.
    logic [7:0] rx_q [$];
    int         rx_cyc [$];
    int         cyc = 0;
    int         rises = 0;
    logic [7:0] mosi_sh = 8'h00;
    logic       sclk_prev = 1'b0;

    always @(negedge dclk) begin
        cyc++;
        if (rx_valid) begin
            rx_q.push_back(rx_byte);
            rx_cyc.push_back(cyc);
        end
        if (sclk && !sclk_prev) begin
            rises++;
            mosi_sh = {mosi_sh[6:0], mosi};
        end
        sclk_prev = sclk;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        put = 1'b1;
        din = b;
        @(posedge dclk);
        #1;
        put = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge dclk);
        #1;
    endtask

    task automatic wait_rx(input int target, input int budget, input string tag);
        int n = 0;
        while (rx_q.size() < target && n < budget) begin
            @(negedge dclk);
            #1;
            n++;
        end
        chk1(tag, rx_q.size() >= target, 1'b1);
    endtask

    task automatic wait_rises(input int target, input int budget, input string tag);
        int n = 0;
        while (rises < target && n < budget) begin
            @(negedge dclk);
            #1;
            n++;
        end
        chk1(tag, rises >= target, 1'b1);
    endtask

    initial begin
        int b0;
        int r0;
        int n;

        rst = 1'b1; clr = 1'b0; put = 1'b0; din = 8'h00; miso_drv = 1'b1; loop = 1'b0;
        #12;
        chk1("rst_sclk", sclk, 1'b0);
        chk1("rst_mosi", mosi, 1'b1);
        chk1("rst_rx_valid", rx_valid, 1'b0);
        chk1("rst_full", full, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk8("rst_rx_byte", rx_byte, 8'h00);
        @(posedge dclk);
        #1 rst = 1'b0;
        idle(3);

        // Single byte 0xA5 with miso held high
        b0 = rx_q.size(); r0 = rises;
        put_byte(8'hA5);
        chk1("t1_busy", busy, 1'b1);
        wait_rx(b0 + 1, 200, "t1_timeout");
        idle(10);
        chki("t1_rx_count", rx_q.size() - b0, 1);
        chki("t1_sclk_pulses", rises - r0, 8);
        chk8("t1_mosi_bits", mosi_sh, 8'hA5);
        chk8("t1_rx_byte", rx_byte, 8'hFF);
        chk1("t1_idle_mosi", mosi, 1'b1);
        chk1("t1_idle_sclk", sclk, 1'b0);
        chk1("t1_idle_busy", busy, 1'b0);

        // Loopback, two bytes back-to-back
        loop = 1'b1;
        b0 = rx_q.size();
        put_byte(8'h3C);
        put_byte(8'hC3);
        wait_rx(b0 + 2, 300, "t2_timeout");
        idle(5);
        chki("t2_rx_count", rx_q.size() - b0, 2);
        chk8("t2_first", rx_q[b0], 8'h3C);
        chk8("t2_second", rx_q[b0 + 1], 8'hC3);
        chki("t2_gap", rx_cyc[b0 + 1] - rx_cyc[b0], 34);
        chk8("t2_rx_byte", rx_byte, 8'hC3);

        // Overflow: 10 consecutive puts, the 10th is rejected
        b0 = rx_q.size();
        for (int i = 0; i < 10; i++) begin
            put_byte(8'(i));
            if (i == 7) chk1("t3_full_after_7", full, 1'b0);
            if (i == 8) chk1("t3_full_after_8", full, 1'b1);
        end
        chk1("t3_full_after_9", full, 1'b1);
        wait_rx(b0 + 9, 600, "t3_timeout");
        idle(60);
        chki("t3_rx_count", rx_q.size() - b0, 9);
        for (int i = 0; i < 9; i++) begin
            chk8($sformatf("t3_byte%0d", i), rx_q[b0 + i], 8'(i));
        end

        // Simultaneous put and pop while full
        b0 = rx_q.size();
        for (int i = 0; i < 9; i++) put_byte(8'h10 + 8'(i));
        chk1("t4_full", full, 1'b1);
        n = 0;
        while (!rx_valid && n < 100) begin
            @(negedge dclk);
            #1;
            n++;
        end
        chk1("t4_pop_seen", rx_valid, 1'b1);
        put = 1'b1; din = 8'h99;
        @(posedge dclk);
        #1 put = 1'b0;
        chk1("t4_full_kept", full, 1'b1);
        wait_rx(b0 + 10, 700, "t4_timeout");
        idle(60);
        chki("t4_rx_count", rx_q.size() - b0, 10);
        for (int i = 0; i < 9; i++) begin
            chk8($sformatf("t4_byte%0d", i), rx_q[b0 + i], 8'h10 + 8'(i));
        end
        chk8("t4_last", rx_q[b0 + 9], 8'h99);

        // clr at bit 4 of 0x81 with 3 bytes queued; put in the clr cycle dropped
        b0 = rx_q.size(); r0 = rises;
        put_byte(8'h81);
        put_byte(8'h01);
        put_byte(8'h02);
        put_byte(8'h03);
        wait_rises(r0 + 4, 200, "t5_timeout");
        clr = 1'b1; put = 1'b1; din = 8'h77;
        @(posedge dclk);
        #1;
        clr = 1'b0; put = 1'b0;
        chk1("t5_sclk", sclk, 1'b0);
        chk1("t5_mosi", mosi, 1'b1);
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_full", full, 1'b0);
        r0 = rises;
        idle(80);
        chki("t5_no_rx", rx_q.size() - b0, 0);
        chki("t5_no_sclk", rises - r0, 0);
        chk1("t5_busy_later", busy, 1'b0);

        // Asynchronous reset mid-byte, then a clean transfer
        loop = 1'b0; miso_drv = 1'b0;
        b0 = rx_q.size(); r0 = rises;
        put_byte(8'h5A);
        wait_rises(r0 + 3, 200, "t6_timeout");
        #2 rst = 1'b1;
        #1;
        chk1("t6_sclk", sclk, 1'b0);
        chk1("t6_mosi", mosi, 1'b1);
        chk1("t6_rx_valid", rx_valid, 1'b0);
        chk1("t6_full", full, 1'b0);
        chk1("t6_busy", busy, 1'b0);
        chk8("t6_rx_byte", rx_byte, 8'h00);
        @(posedge dclk);
        #1 rst = 1'b0;
        idle(2);
        chki("t6_no_rx", rx_q.size() - b0, 0);
        loop = 1'b1;
        r0 = rises;
        put_byte(8'h55);
        wait_rx(b0 + 1, 200, "t6_post_timeout");
        idle(5);
        chki("t6_post_count", rx_q.size() - b0, 1);
        chk8("t6_post_rx", rx_q[b0], 8'h55);
        chk8("t6_post_rx_byte", rx_byte, 8'h55);
        chk8("t6_post_mosi_bits", mosi_sh, 8'h55);
        chki("t6_post_pulses", rises - r0, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
